serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
Bit-serial unsigned subtractor computing input_1 - input_2 one bit per clock, LSB first, using a single full-subtractor cell and a borrow flip-flop. It is the sequential counterpart of the adder datapath and is used where area matters more than latency. Operands are captured on a start pulse. The result is presented with a one-cycle done strobe and held until the next result completes.

Parameters:
WIDTH, 8, operand and result width in bits (minimum 2)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous reset, active-high
start  input  1  request; sampled only in IDLE
input_1  input  WIDTH  minuend, captured on accepted start
input_2  input  WIDTH  subtrahend, captured on accepted start
busy  output  1  high while in SHIFT or DONE state
done  output  1  one-cycle strobe, result valid
difference  output  WIDTH  (input_1 - input_2) mod 2^WIDTH, held between completions
borrow  output  1  final borrow; 1 iff input_1 < input_2 (unsigned)

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE. busy=0, done=0, difference=0, borrow=0. Operand shift registers, borrow flip-flop and bit counter are cleared.
- States: IDLE, SHIFT, DONE.
- IDLE: if start=1, latch input_1/input_2 into shift registers A/B, clear borrow flip-flop br=0 and counter cnt=0, then go to SHIFT. Otherwise stay in IDLE.
- SHIFT, each cycle:
  - d = A[0] ^ B[0] ^ br
  - br_next = (~A[0] & B[0]) | (~(A[0] ^ B[0]) & br)
  - d shifts into the MSB of internal result register R (R shifts right); A and B shift right; cnt increments.
  - When cnt reaches WIDTH-1 in this cycle (the last bit), go to DONE.
- DONE, one cycle:
  - difference <= R (final bit included), borrow <= br.
  - done=1 for exactly this cycle, then return to IDLE.
- busy=1 in SHIFT and DONE, 0 in IDLE.
- Latency: start accepted at edge T; SHIFT occupies edges T+1..T+WIDTH; done is high during the cycle after edge T+WIDTH+1. Total is WIDTH+2 edges from start to done-visible. Throughput is one operation per WIDTH+2 cycles.
- start while busy=1 (SHIFT or DONE) is ignored, with no queuing. start in the cycle after done (IDLE) is accepted normally.
- difference and borrow change only on entry to DONE. They hold stale-but-valid values during a following operation.
- Input operand changes after capture have no effect on the operation in progress.
- Reset mid-operation aborts it: no done pulse, and outputs return to 0.
- Wrap-around: the result is modulo 2^WIDTH. Borrow is the only underflow indication.

Test Plan:
1. WIDTH=8, input_1=0x05, input_2=0x03, start one cycle -> done once, WIDTH+2 edges after start; difference=0x02, borrow=0; busy high for 9 cycles.
2. input_1=0x03, input_2=0x05 -> difference=0xFE, borrow=1. Then input_1=0x00, input_2=0xFF -> difference=0x01, borrow=1.
3. Equal and extreme operands: 0xA5-0xA5 -> 0x00, borrow=0. 0xFF-0x00 -> 0xFF, borrow=0. 0x80-0x01 -> 0x7F, borrow=0.
4. Start 0x10-0x01, then pulse start with 0x00-0x01 and change operands during SHIFT -> single done; difference=0x0F, borrow=0; second start ignored.
5. Start 0x20-0x10, assert rst at the 4th SHIFT cycle -> no done; busy=0, difference=0, borrow=0 next cycle. A fresh start 0x09-0x04 then yields 0x05, borrow=0.
6. Back-to-back: start asserted in the IDLE cycle right after done, 100 random operand pairs -> each result matches the (a-b) mod 256 and a<b reference. difference holds the previous result until each new done.

Source files
------------

// File: rtl/serial_subtractor_if.sv
// rtl/serial_subtractor_if.sv - request/result bundle for the bit-serial subtractor
//
// Purpose: groups the operand request and result signals of serial_subtractor.
// Signals:
//   start       request pulse, sampled by the subtractor only while idle
//   input_1     minuend, captured on an accepted start
//   input_2     subtrahend, captured on an accepted start
//   busy        subtractor is shifting or finishing
//   done        one-cycle strobe, difference/borrow just updated
//   difference  (input_1 - input_2) mod 2^WIDTH, held between completions
//   borrow      1 iff input_1 < input_2 (unsigned)
// Modports: master drives the request, slave (the subtractor) drives results.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
) ();
  logic             start;
  logic [WIDTH-1:0] input_1;
  logic [WIDTH-1:0] input_2;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] difference;
  logic             borrow;

  modport master (
    output start, input_1, input_2,
    input  busy, done, difference, borrow
  );

  modport slave (
    input  start, input_1, input_2,
    output busy, done, difference, borrow
  );
endinterface

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial unsigned subtractor, LSB first
//
// Purpose: computes input_1 - input_2 one bit per clock with a single
// full-subtractor cell and a borrow flip-flop.
// Ports:
//   clk  system clock, rising edge
//   rst  synchronous reset, active-high
//   bus  serial_subtractor_if.slave (start/operands in, busy/done/result out)
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  serial_subtractor_if.slave    bus
);

  localparam int              CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_r;
  logic             r_br;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_diff;
  logic             r_borrow;

  logic             w_d;
  logic             w_br_next;

  // Full-subtractor cell on the current LSBs.
  assign w_d       = r_a[0] ^ r_b[0] ^ r_br;
  assign w_br_next = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_br);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_r      <= '0;
      r_br     <= 1'b0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_diff   <= '0;
      r_borrow <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_a     <= bus.input_1;
            r_b     <= bus.input_2;
            r_br    <= 1'b0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          // Result fills from the MSB side so bit 0 lands at R[0] after WIDTH shifts.
          r_a   <= r_a >> 1;
          r_b   <= r_b >> 1;
          r_r   <= {w_d, r_r[WIDTH-1:1]};
          r_br  <= w_br_next;
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == LAST) begin
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_diff   <= r_r;
          r_borrow <= r_br;
          r_done   <= 1'b1;
          r_busy   <= 1'b0;
          r_state  <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.difference = r_diff;
  assign bus.borrow     = r_borrow;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - self-checking bench for serial_subtractor
module tb_serial_subtractor;

  localparam int WIDTH = 8;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;

  serial_subtractor_if #(.WIDTH(WIDTH)) bus ();

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: unsigned subtraction modulo 2^WIDTH, borrow when minuend < subtrahend.
  function automatic logic [WIDTH-1:0] ref_diff(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    int unsigned full;
    full = (int'(a) + (1 << WIDTH) - int'(b)) % (1 << WIDTH);
    return WIDTH'(full);
  endfunction

  function automatic logic ref_borrow(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    return int'(a) < int'(b);
  endfunction

  // Issues one start and waits for done. lat counts edges after the accepting
  // edge until done is seen (-1 on timeout); busy_cyc counts cycles with busy=1.
  task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       output int lat, output int busy_cyc);
    bus.input_1 = a;
    bus.input_2 = b;
    bus.start   = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    busy_cyc  = int'(bus.busy);
    lat       = -1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (bus.done) begin
        lat = c;
        break;
      end
      busy_cyc += int'(bus.busy);
    end
  endtask

  task automatic test_reset;
    bus.start   = 1'b0;
    bus.input_1 = '0;
    bus.input_2 = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    n_checks++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got %b want 0", bus.busy); else n_pass++;
    n_checks++; if (bus.done !== 1'b0) $display("FAIL reset_done got %b want 0", bus.done); else n_pass++;
    n_checks++; if (bus.difference !== '0) $display("FAIL reset_difference got %h want 00", bus.difference); else n_pass++;
    n_checks++; if (bus.borrow !== 1'b0) $display("FAIL reset_borrow got %b want 0", bus.borrow); else n_pass++;
  endtask

  task automatic test_basic;
    int lat, busy_cyc;
    do_op(8'h05, 8'h03, lat, busy_cyc);
    // Done visible after edge T+WIDTH+1, i.e. WIDTH+2 edges counting the accepting edge.
    n_checks++; if (lat !== WIDTH + 1) $display("FAIL basic_latency got %0d want %0d", lat, WIDTH + 1); else n_pass++;
    n_checks++; if (busy_cyc !== WIDTH + 1) $display("FAIL basic_busy_cycles got %0d want %0d", busy_cyc, WIDTH + 1); else n_pass++;
    n_checks++; if (bus.difference !== ref_diff(8'h05, 8'h03)) $display("FAIL basic_difference got %h want %h", bus.difference, ref_diff(8'h05, 8'h03)); else n_pass++;
    n_checks++; if (bus.borrow !== ref_borrow(8'h05, 8'h03)) $display("FAIL basic_borrow got %b want %b", bus.borrow, ref_borrow(8'h05, 8'h03)); else n_pass++;
    @(posedge clk); #1;
    n_checks++; if (bus.done !== 1'b0) $display("FAIL basic_done_strobe got %b want 0", bus.done); else n_pass++;
  endtask

  task automatic test_pairs(input string name, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    int lat, busy_cyc;
    do_op(a, b, lat, busy_cyc);
    n_checks++; if (lat !== WIDTH + 1) $display("FAIL %s_latency got %0d want %0d", name, lat, WIDTH + 1); else n_pass++;
    n_checks++; if (bus.difference !== ref_diff(a, b)) $display("FAIL %s_difference got %h want %h", name, bus.difference, ref_diff(a, b)); else n_pass++;
    n_checks++; if (bus.borrow !== ref_borrow(a, b)) $display("FAIL %s_borrow got %b want %b", name, bus.borrow, ref_borrow(a, b)); else n_pass++;
  endtask

  task automatic test_underflow;
    test_pairs("underflow_03_05", 8'h03, 8'h05);
    test_pairs("underflow_00_ff", 8'h00, 8'hFF);
  endtask

  task automatic test_extremes;
    test_pairs("equal_a5", 8'hA5, 8'hA5);
    test_pairs("max_ff_00", 8'hFF, 8'h00);
    test_pairs("msb_80_01", 8'h80, 8'h01);
  endtask

  task automatic test_ignore_start;
    int dones;
    logic [WIDTH-1:0] d;
    logic b;
    dones = 0;
    d = '0;
    b = 1'b1;
    bus.input_1 = 8'h10;
    bus.input_2 = 8'h01;
    bus.start   = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int c = 0; c < 30; c++) begin
      if (c == 2) begin
        bus.start   = 1'b1;
        bus.input_1 = 8'h00;
        bus.input_2 = 8'h01;
      end else begin
        bus.start = 1'b0;
        if (c > 2 && c < 8) begin
          bus.input_1 = WIDTH'($urandom);
          bus.input_2 = WIDTH'($urandom);
        end
      end
      @(posedge clk); #1;
      if (bus.done) begin
        dones++;
        d = bus.difference;
        b = bus.borrow;
      end
    end
    n_checks++; if (dones !== 1) $display("FAIL ignore_done_count got %0d want 1", dones); else n_pass++;
    n_checks++; if (d !== ref_diff(8'h10, 8'h01)) $display("FAIL ignore_difference got %h want %h", d, ref_diff(8'h10, 8'h01)); else n_pass++;
    n_checks++; if (b !== ref_borrow(8'h10, 8'h01)) $display("FAIL ignore_borrow got %b want %b", b, ref_borrow(8'h10, 8'h01)); else n_pass++;
  endtask

  task automatic test_reset_mid;
    int dones;
    dones = 0;
    bus.input_1 = 8'h20;
    bus.input_2 = 8'h10;
    bus.start   = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_checks++; if (bus.busy !== 1'b0) $display("FAIL midreset_busy got %b want 0", bus.busy); else n_pass++;
    n_checks++; if (bus.difference !== '0) $display("FAIL midreset_difference got %h want 00", bus.difference); else n_pass++;
    n_checks++; if (bus.borrow !== 1'b0) $display("FAIL midreset_borrow got %b want 0", bus.borrow); else n_pass++;
    for (int c = 0; c < 15; c++) begin
      if (bus.done) dones++;
      @(posedge clk); #1;
    end
    n_checks++; if (dones !== 0) $display("FAIL midreset_no_done got %0d want 0", dones); else n_pass++;
    test_pairs("after_reset_09_04", 8'h09, 8'h04);
  endtask

  task automatic test_back_to_back;
    logic [WIDTH-1:0] a, b, prev_d;
    int hold_err, bad_res, bad_lat, lat;
    logic got;
    hold_err = 0;
    bad_res  = 0;
    bad_lat  = 0;
    prev_d   = '0;
    a = WIDTH'($urandom);
    b = WIDTH'($urandom);
    bus.input_1 = a;
    bus.input_2 = b;
    bus.start   = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      bus.start   = 1'b0;
      bus.input_1 = WIDTH'($urandom);
      bus.input_2 = WIDTH'($urandom);
      got = 1'b0;
      lat = 0;
      while (!got && lat < 40) begin
        @(posedge clk); #1;
        lat++;
        if (bus.done) got = 1'b1;
        else if (i > 0 && bus.difference !== prev_d) hold_err++;
      end
      if (!got) begin
        $display("FAIL b2b_timeout op %0d no done within 40 cycles", i);
        bad_lat++;
        break;
      end
      if (lat != WIDTH + 1) bad_lat++;
      if (bus.difference !== ref_diff(a, b) || bus.borrow !== ref_borrow(a, b)) begin
        if (bad_res < 5)
          $display("FAIL b2b_result op %0d a=%h b=%h got %h/%b want %h/%b",
                   i, a, b, bus.difference, bus.borrow, ref_diff(a, b), ref_borrow(a, b));
        bad_res++;
      end
      prev_d = ref_diff(a, b);
      if (i < 99) begin
        a = WIDTH'($urandom);
        b = WIDTH'($urandom);
        bus.input_1 = a;
        bus.input_2 = b;
        bus.start   = 1'b1;
      end
    end
    bus.start = 1'b0;
    n_checks++; if (bad_res !== 0) $display("FAIL b2b_results got %0d bad want 0", bad_res); else n_pass++;
    n_checks++; if (bad_lat !== 0) $display("FAIL b2b_latency got %0d bad want 0", bad_lat); else n_pass++;
    n_checks++; if (hold_err !== 0) $display("FAIL b2b_hold got %0d changes want 0", hold_err); else n_pass++;
  endtask

  initial begin
    n_checks    = 0;
    n_pass      = 0;
    rst         = 1'b1;
    bus.start   = 1'b0;
    bus.input_1 = '0;
    bus.input_2 = '0;
    test_reset();
    test_basic();
    test_underflow();
    test_extremes();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
